// File: rtl/pipeline_narray_gemv_acc.sv
// -----------------------------------------------------------------------------
// pipeline_narray_gemv_acc
//
// Tiled GEMV engine. Each accepted beat carries one TILE_SIZE x TILE_SIZE A
// tile and one TILE_SIZE B slice. The engine forms the fixed-point row
// dot-products, floor-shifts them by FRAC_BITS and accumulates them over
// cfg_k_tiles beats. It then presents one TILE_SIZE-row result vector.
//
// Timing: a beat accepted at edge E updates the accumulators at edge
// E+NUM_STAGES. The result becomes visible after edge E+NUM_STAGES+1 when the
// output is not stalled.
//
// Optional feature macro: SATURATE_EN
//   defined   -> accumulation clamps to the signed ACC_WIDTH range and sets the
//                sticky sat_flag
//   undefined -> accumulation wraps modulo 2^ACC_WIDTH, and sat_flag is tied 0
//
// Ports:
//   clk          clock
//   rst_n        asynchronous reset, ACTIVE-HIGH despite the name
//   cfg_k_tiles  beats per group, sampled on the first beat (0 counts as 1)
//   in_valid     input beat valid
//   in_ready     input beat ready
//   in_a         A tile, element [i][j] at flat index i*TILE_SIZE+j
//   in_b         B slice, element j at flat index j
//   out_valid    result valid, held until out_ready
//   out_ready    result consume
//   out_y        row results, row i at flat index i
//   done_tile    one-cycle pulse when out_y is loaded
//   busy         group in progress (ACCUM or DRAIN)
//   sat_flag     sticky saturation indicator, cleared on a group's first beat
// -----------------------------------------------------------------------------
module pipeline_narray_gemv_acc #(
  parameter int TILE_SIZE  = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int FRAC_BITS  = 8,
  parameter int NUM_STAGES = 4,
  parameter int KT_W       = 8
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic [KT_W-1:0]                            cfg_k_tiles,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic [TILE_SIZE*TILE_SIZE*DATA_WIDTH-1:0]  in_a,
  input  logic [TILE_SIZE*DATA_WIDTH-1:0]            in_b,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [TILE_SIZE*ACC_WIDTH-1:0]             out_y,
  output logic                                       done_tile,
  output logic                                       busy,
  output logic                                       sat_flag
);

  localparam int PW = 2 * DATA_WIDTH;                 // product width
  localparam int SW = PW + $clog2(TILE_SIZE);         // row-sum width
  localparam int NE = TILE_SIZE * TILE_SIZE;          // elements per A tile
  localparam int CL = NUM_STAGES - 1;                 // row-sum stage + delays

  typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_DRAIN} state_t;

  // ---------------------------------------------------------------------------
  // Group control
  // ---------------------------------------------------------------------------
  state_t          state_q, state_d;
  logic [KT_W-1:0] kt_q, kt_d;
  logic [KT_W-1:0] cnt_q, cnt_d;
  logic [KT_W-1:0] kt_eff, cnt_inc;
  logic            accept, first_beat, last_beat;

  assign in_ready   = (state_q != ST_DRAIN);
  assign busy       = (state_q != ST_IDLE);
  assign accept     = in_valid && in_ready;
  assign kt_eff     = (cfg_k_tiles == '0) ? KT_W'(1) : cfg_k_tiles;
  assign cnt_inc    = cnt_q + KT_W'(1);
  assign first_beat = accept && (state_q == ST_IDLE);
  assign last_beat  = accept && ((state_q == ST_IDLE) ? (kt_eff == KT_W'(1))
                                                      : (cnt_inc == kt_q));

  // ---------------------------------------------------------------------------
  // Stage 1: element products
  // ---------------------------------------------------------------------------
  logic                 s1_v_q, s1_f_q, s1_l_q;
  logic signed [PW-1:0] prod_q [NE];
  logic signed [PW-1:0] prod_d [NE];

  // NOTE: every variable assigned in an always_comb block gets a value on every
  // path, or its default is set first. A path that leaves one unassigned
  // infers a latch.
  always_comb begin
    for (int e = 0; e < NE; e++) begin
      prod_d[e] = PW'($signed(in_a[e*DATA_WIDTH +: DATA_WIDTH])) *
                  PW'($signed(in_b[(e % TILE_SIZE)*DATA_WIDTH +: DATA_WIDTH]));
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 (row sum, floor-shifted to ACC_WIDTH) followed by NUM_STAGES-2
  // delay stages. Slot 0 of the chain is stage 2. Slot CL-1 feeds the
  // accumulators. The shift is folded into stage 2, so the delay stages carry
  // only ACC_WIDTH bits per row.
  // ---------------------------------------------------------------------------
  logic [CL-1:0]               ch_v_q, ch_v_d, ch_f_q, ch_f_d, ch_l_q, ch_l_d;
  logic signed [ACC_WIDTH-1:0] ch_c_q [CL][TILE_SIZE];
  logic signed [ACC_WIDTH-1:0] ch_c_d [CL][TILE_SIZE];

  always_comb begin : p_chain
    logic signed [SW-1:0] s;
    logic signed [SW-1:0] sh;
    ch_v_d = ch_v_q;
    ch_f_d = ch_f_q;
    ch_l_d = ch_l_q;
    ch_c_d = ch_c_q;
    s      = '0;
    sh     = '0;
    ch_v_d[0] = s1_v_q;
    ch_f_d[0] = s1_f_q;
    ch_l_d[0] = s1_l_q;
    for (int i = 0; i < TILE_SIZE; i++) begin
      s = '0;
      for (int j = 0; j < TILE_SIZE; j++) begin
        s = s + SW'(prod_q[i*TILE_SIZE + j]);
      end
      sh           = s >>> FRAC_BITS;          // arithmetic shift: floor
      ch_c_d[0][i] = ACC_WIDTH'(sh);
    end
    for (int k = 1; k < CL; k++) begin
      ch_v_d[k] = ch_v_q[k-1];
      ch_f_d[k] = ch_f_q[k-1];
      ch_l_d[k] = ch_l_q[k-1];
      ch_c_d[k] = ch_c_q[k-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Accumulators and result register
  // ---------------------------------------------------------------------------
  logic signed [ACC_WIDTH-1:0] acc_q   [TILE_SIZE];
  logic signed [ACC_WIDTH-1:0] acc_d   [TILE_SIZE];
  logic signed [ACC_WIDTH-1:0] out_y_q [TILE_SIZE];
  logic signed [ACC_WIDTH-1:0] out_y_d [TILE_SIZE];
  logic acc_done_q, acc_done_d;   // the group's last beat has reached acc
  logic out_valid_q, out_valid_d;
  logic done_q, done_d;
  logic drain_exit;
`ifdef SATURATE_EN
  logic sat_q, sat_d;
`endif

  assign drain_exit = (state_q == ST_DRAIN) && acc_done_q &&
                      (!out_valid_q || out_ready);

  always_comb begin : p_acc
`ifdef SATURATE_EN
    logic signed [ACC_WIDTH:0] wide;
    logic                      sat_hit;
    wide    = '0;
    sat_hit = 1'b0;
`endif
    acc_d = acc_q;
    if (ch_v_q[CL-1]) begin
      for (int i = 0; i < TILE_SIZE; i++) begin
        if (ch_f_q[CL-1]) begin
          acc_d[i] = ch_c_q[CL-1][i];
        end else begin
`ifdef SATURATE_EN
          wide = {acc_q[i][ACC_WIDTH-1], acc_q[i]} +
                 {ch_c_q[CL-1][i][ACC_WIDTH-1], ch_c_q[CL-1][i]};
          // The sign bits disagree only when the sum left the ACC_WIDTH range.
          if (wide[ACC_WIDTH] != wide[ACC_WIDTH-1]) begin
            sat_hit  = 1'b1;
            acc_d[i] = wide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                       : {1'b0, {(ACC_WIDTH-1){1'b1}}};
          end else begin
            acc_d[i] = wide[ACC_WIDTH-1:0];
          end
`else
          acc_d[i] = acc_q[i] + ch_c_q[CL-1][i];
`endif
        end
      end
    end
`ifdef SATURATE_EN
    // The previous group has fully drained before a first beat can be accepted.
    // A clear and a clamp therefore never belong to the same group.
    sat_d = sat_hit ? 1'b1 : (first_beat ? 1'b0 : sat_q);
`endif
  end

  always_comb begin
    acc_done_d = acc_done_q;
    if (drain_exit)                          acc_done_d = 1'b0;
    else if (ch_v_q[CL-1] && ch_l_q[CL-1])   acc_done_d = 1'b1;

    out_y_d     = drain_exit ? acc_q : out_y_q;
    done_d      = drain_exit;
    out_valid_d = out_valid_q;
    if (drain_exit)                      out_valid_d = 1'b1;
    else if (out_valid_q && out_ready)   out_valid_d = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    kt_d    = kt_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: if (accept) begin
        kt_d    = kt_eff;
        cnt_d   = KT_W'(1);
        state_d = (kt_eff == KT_W'(1)) ? ST_DRAIN : ST_ACCUM;
      end
      ST_ACCUM: if (accept) begin
        cnt_d = cnt_inc;
        if (cnt_inc == kt_q) state_d = ST_DRAIN;
      end
      ST_DRAIN: if (drain_exit) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: pipeline data registers have no reset. Their valid tags are reset,
  // and stale data is never used without a valid tag.
  always_ff @(posedge clk) begin
    if (accept) prod_q <= prod_d;
    ch_c_q <= ch_c_d;
  end

  // NOTE: sequential state uses non-blocking assignments only. Every flop then
  // samples the values from before the edge, whatever the statement order.
  // The reset of this block is asserted while rst_n is high.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q     <= ST_IDLE;
      kt_q        <= '0;
      cnt_q       <= '0;
      s1_v_q      <= 1'b0;
      s1_f_q      <= 1'b0;
      s1_l_q      <= 1'b0;
      ch_v_q      <= '0;
      ch_f_q      <= '0;
      ch_l_q      <= '0;
      acc_done_q  <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < TILE_SIZE; i++) begin
        acc_q[i]   <= '0;
        out_y_q[i] <= '0;
      end
`ifdef SATURATE_EN
      sat_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      kt_q        <= kt_d;
      cnt_q       <= cnt_d;
      s1_v_q      <= accept;
      s1_f_q      <= first_beat;
      s1_l_q      <= last_beat;
      ch_v_q      <= ch_v_d;
      ch_f_q      <= ch_f_d;
      ch_l_q      <= ch_l_d;
      acc_done_q  <= acc_done_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      acc_q       <= acc_d;
      out_y_q     <= out_y_d;
`ifdef SATURATE_EN
      sat_q       <= sat_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign out_valid = out_valid_q;
  assign done_tile = done_q;
`ifdef SATURATE_EN
  assign sat_flag  = sat_q;
`else
  assign sat_flag  = 1'b0;
`endif

  for (genvar gi = 0; gi < TILE_SIZE; gi++) begin : g_out
    assign out_y[gi*ACC_WIDTH +: ACC_WIDTH] = out_y_q[gi];
  end

endmodule

// File: tb/tb_pipeline_narray_gemv_acc.sv
// -----------------------------------------------------------------------------
// tb_pipeline_narray_gemv_acc
//
// Directed testbench for pipeline_narray_gemv_acc with its default parameters
// (4x4 tiles, 16-bit data, 32-bit accumulators, 8 fraction bits, 4 stages).
// The bench holds its own expected values and computes the GEMV golden values
// itself. rst_n is active-high.
// -----------------------------------------------------------------------------
module tb_pipeline_narray_gemv_acc;

  localparam int TS = 4;
  localparam int DW = 16;
  localparam int AW = 32;
  localparam int KW = 8;

  typedef logic [TS*TS*DW-1:0] a_t;
  typedef logic [TS*DW-1:0]    b_t;
  typedef logic [TS*AW-1:0]    y_t;

  logic          clk;
  logic          rst_n;
  logic [KW-1:0] cfg_k_tiles;
  logic          in_valid;
  logic          in_ready;
  a_t            in_a;
  b_t            in_b;
  logic          out_valid;
  logic          out_ready;
  y_t            out_y;
  logic          done_tile;
  logic          busy;
  logic          sat_flag;

  pipeline_narray_gemv_acc #(
    .TILE_SIZE (TS),
    .DATA_WIDTH(DW),
    .ACC_WIDTH (AW),
    .FRAC_BITS (8),
    .NUM_STAGES(4),
    .KT_W      (KW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_k_tiles(cfg_k_tiles),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_y      (out_y),
    .done_tile  (done_tile),
    .busy       (busy),
    .sat_flag   (sat_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total    = 0;
  int bad      = 0;
  int done_cnt = 0;
  y_t res_q[$];

  // Record every result at the moment it is loaded.
  always @(negedge clk) begin
    if (done_tile) begin
      res_q.push_back(out_y);
      done_cnt++;
    end
  end

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint row(input y_t y, input int i);
    logic signed [AW-1:0] t;
    t = y[i*AW +: AW];
    return longint'(t);
  endfunction

  function automatic a_t fill_a(input int v);
    a_t a;
    for (int e = 0; e < TS*TS; e++) a[e*DW +: DW] = DW'(v);
    return a;
  endfunction

  function automatic b_t fill_b(input int v);
    b_t b;
    for (int e = 0; e < TS; e++) b[e*DW +: DW] = DW'(v);
    return b;
  endfunction

  function automatic y_t last_result();
    if (res_q.size() > 0) return res_q[res_q.size()-1];
    return '0;
  endfunction

  // Present one beat and hold it until it is accepted. Returns 1 time unit
  // after the accepting edge.
  task automatic send_beat(input a_t a, input b_t b, input int kt);
    int n;
    @(negedge clk);
    in_a        = a;
    in_b        = b;
    cfg_k_tiles = KW'(kt);
    in_valid    = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("in_ready_timeout", longint'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt < target) check("wait_done_timeout", done_cnt, target);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int     base;
    y_t     y1;
    int     v_rdy, v_y, v_done, v_val;
    longint gold [40];
    a_t     a;
    b_t     b;
    longint s;
    longint exp_ovf;
    int     exp_sat;

    rst_n       = 1'b1;
    in_valid    = 1'b0;
    in_a        = '0;
    in_b        = '0;
    cfg_k_tiles = '0;
    out_ready   = 1'b0;

    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_done_tile", done_tile, 0);
    check("rst_busy", busy, 0);
    check("rst_sat_flag", sat_flag, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_y0", row(out_y, 0), 0);
    check("rst_out_y3", row(out_y, 3), 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);

    // ---------------- basic k_tiles=1, latency ----------------
    // 256*512 = 131072, four terms give 524288, and >>>8 gives 2048.
    send_beat(fill_a(256), fill_b(512), 1);
    repeat (4) @(posedge clk);
    #1;
    check("lat_done_early", done_tile, 0);
    @(posedge clk);
    #1;
    check("lat_done_tile", done_tile, 1);
    check("lat_out_valid", out_valid, 1);
    for (int i = 0; i < TS; i++) check($sformatf("basic_row%0d", i), row(out_y, i), 2048);
    @(posedge clk);
    #1;
    check("done_pulse_one_cycle", done_tile, 0);
    check("out_valid_hold", out_valid, 1);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("out_valid_consumed", out_valid, 0);

    // ---------------- negative floor ----------------
    // Each row sums to -4, and -4 >>> 8 floors to -1.
    base = done_cnt;
    send_beat(fill_a(-1), fill_b(1), 1);
    wait_done(base + 1, 50);
    for (int i = 0; i < TS; i++) check($sformatf("negfloor_row%0d", i), row(last_result(), i), -1);

    // ---------------- GEMV 40x256, k_tiles=64, 10 groups ----------------
    for (int r = 0; r < 40; r++) gold[r] = 0;
    res_q.delete();
    base = done_cnt;
    for (int g = 0; g < 10; g++) begin
      for (int t = 0; t < 64; t++) begin
        for (int i = 0; i < TS; i++) begin
          s = 0;
          for (int j = 0; j < TS; j++) begin
            int r, k, av, bv;
            r  = 4*g + i;
            k  = 4*t + j;
            av = ((r % 5) - 2) * 256 + ((k % 7) - 3);
            bv = ((k % 9) - 4) * 128;
            a[(i*TS + j)*DW +: DW] = DW'(av);
            b[j*DW +: DW]          = DW'(bv);
            s = s + longint'(av) * longint'(bv);
          end
          gold[4*g + i] = gold[4*g + i] + (s >>> 8);
        end
        send_beat(a, b, 64);
      end
    end
    wait_done(base + 10, 200);
    repeat (10) @(posedge clk);
    check("gemv_done_count", done_cnt - base, 10);
    for (int g = 0; g < 10; g++) begin
      for (int i = 0; i < TS; i++) begin
        longint got;
        got = (g < res_q.size()) ? row(res_q[g], i) : 0;
        check($sformatf("gemv_row%0d", 4*g + i), got, gold[4*g + i]);
      end
    end

    // ---------------- output backpressure ----------------
    @(negedge clk);
    out_ready = 1'b0;
    base = done_cnt;
    send_beat(fill_a(256), fill_b(256), 1);   // each row: 262144 >>> 8 = 1024
    wait_done(base + 1, 50);
    y1 = last_result();
    check("bp_g1_row0", row(y1, 0), 1024);
    // The second group is accepted while the first result is still pending.
    // Each beat gives -524288 >>> 8 = -2048, so four beats give -8192.
    for (int t = 0; t < 4; t++) send_beat(fill_a(512), fill_b(-256), 4);
    v_rdy = 0; v_y = 0; v_done = 0; v_val = 0;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk);
      #1;
      if (in_ready !== 1'b0) v_rdy++;
      if (out_y !== y1) v_y++;
      if (done_tile !== 1'b0) v_done++;
      if (out_valid !== 1'b1) v_val++;
    end
    check("bp_in_ready_low_cycles", v_rdy, 0);
    check("bp_out_y_changed_cycles", v_y, 0);
    check("bp_done_pulses", v_done, 0);
    check("bp_out_valid_drop_cycles", v_val, 0);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_reload_done", done_tile, 1);
    check("bp_reload_valid", out_valid, 1);
    for (int i = 0; i < TS; i++) check($sformatf("bp_g2_row%0d", i), row(out_y, i), -8192);
    @(posedge clk);
    #1;
    check("bp_g2_consumed", out_valid, 0);

    // ---------------- overflow, k_tiles=200 ----------------
    // 4*32767^2 >>> 8 = 16776192 per beat, and 200 beats give 3355238400.
`ifdef SATURATE_EN
    exp_ovf = 2147483647;
    exp_sat = 1;
`else
    exp_ovf = -939728896;
    exp_sat = 0;
`endif
    base = done_cnt;
    for (int t = 0; t < 200; t++) send_beat(fill_a(32767), fill_b(32767), 200);
    wait_done(base + 1, 100);
    for (int i = 0; i < TS; i++) check($sformatf("ovf_row%0d", i), row(last_result(), i), exp_ovf);
    check("ovf_sat_flag", sat_flag, exp_sat);

    // ---------------- reset mid-group ----------------
    base = done_cnt;
    for (int t = 0; t < 3; t++) send_beat(fill_a(256), fill_b(512), 8);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_sat_flag", sat_flag, 0);
    check("mid_rst_out_y0", row(out_y, 0), 0);
    rst_n = 1'b0;
    repeat (12) @(posedge clk);
    check("mid_rst_no_done", done_cnt - base, 0);
    // 128*256 = 32768, four terms give 131072, and >>>8 gives 512.
    send_beat(fill_a(128), fill_b(256), 1);
    wait_done(base + 1, 50);
    repeat (10) @(posedge clk);
    check("post_rst_done_count", done_cnt - base, 1);
    for (int i = 0; i < TS; i++) check($sformatf("post_rst_row%0d", i), row(last_result(), i), 512);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_narray_gemv_acc.md
Name: pipeline_narray_gemv_acc

Overview:
Parametrised successor to the fixed 4-array MAC pipeline. Accepts one TILE_SIZE x TILE_SIZE A tile plus a TILE_SIZE B slice per beat over valid/ready. Forms fixed-point row dot-products through a NUM_STAGES-deep pipeline and accumulates them internally over a configurable number of K tiles. Emits one TILE_SIZE-row result vector per group with a done_tile pulse, so software-side per-row summation and K-skew scheduling are no longer needed.

Parameters:
TILE_SIZE, 4, rows per tile and K elements per beat
DATA_WIDTH, 16, signed A/B element width
ACC_WIDTH, 32, signed accumulator/output width; must be >= 2*DATA_WIDTH+clog2(TILE_SIZE)-FRAC_BITS
FRAC_BITS, 8, fixed-point fraction bits; arithmetic right shift applied to each row sum
NUM_STAGES, 4, cycles from beat acceptance to accumulator update; must be >= 2
KT_W, 8, width of cfg_k_tiles

Ports:
clk  in  1  clock
rst_n  in  1  reset
cfg_k_tiles  in  KT_W  beats per group; sampled on the first beat of a group; 0 treated as 1
in_valid  in  1  beat valid
in_ready  out  1  beat accepted when in_valid&&in_ready
in_a  in  TILE_SIZE*TILE_SIZE*DATA_WIDTH  A tile, element [i][j] at index i*TILE_SIZE+j
in_b  in  TILE_SIZE*DATA_WIDTH  B slice, element j
out_valid  out  1  result valid
out_ready  in  1  result consumed when out_valid&&out_ready
out_y  out  TILE_SIZE*ACC_WIDTH  row results, row i at index i
done_tile  out  1  one-cycle pulse when out_y is loaded
busy  out  1  high in ACCUM or DRAIN
sat_flag  out  1  sticky saturation indicator, cleared on first beat of a group

Behaviour:
- Reset: rst_n, asynchronous, active-high; clock clk. Reset clears FSM to IDLE, pipeline valids, accumulators, out_y=0, out_valid=0, done_tile=0, sat_flag=0. Reset mid-group discards in-flight beats with no output.
- Arithmetic per beat: p[i][j]=A[i][j]*B[j] at full 2*DATA_WIDTH signed. s[i]=sum over j at 2*DATA_WIDTH+clog2(TILE_SIZE) bits. c[i]=s[i]>>>FRAC_BITS (floor), sign-extended to ACC_WIDTH.
- Pipeline: stage 1 registers products, stage 2 registers row sums, NUM_STAGES-2 delay stages follow. Each beat carries a first tag. At the accumulator, acc[i] <= first ? c[i] : acc[i]+c[i]. A beat accepted at edge E updates acc at edge E+NUM_STAGES.
- FSM IDLE: in_ready=1. An accepted beat latches cfg_k_tiles, sets beat count to 1, and is tagged first. If k_tiles==1 go DRAIN, else go ACCUM. IDLE accepts input even while out_valid holds a previous result.
- FSM ACCUM: in_ready=1, count beats. On accepting beat number k_tiles, go DRAIN.
- FSM DRAIN: in_ready=0. Exit when the last beat has updated acc AND (!out_valid || out_ready). On exit: out_y<=acc, out_valid=1, done_tile=1 for one cycle, go IDLE.
- Unstalled latency: last beat accepted at edge E gives out_valid/done_tile high after edge E+NUM_STAGES+1.
- out_valid stays high and out_y stays stable until the out_ready handshake. A simultaneous consume and reload keeps out_valid=1 with new data.
- in_valid low mid-group inserts bubbles. Beat count and accumulators hold; no timeout.

Optional Feature:
SATURATE_EN: when defined, acc+c is computed at ACC_WIDTH+1 bits and clamped to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]; any clamp sets sat_flag. When undefined, addition wraps modulo 2^ACC_WIDTH and sat_flag is tied 0.

Test Plan:
- Basic, k_tiles=1: all A=256, all B=512 -> every out_y row=2048; out_valid and done_tile high 5 cycles after acceptance (NUM_STAGES=4).
- GEMV 40x256 against golden, k_tiles=64, 10 row groups: A[r][k]=((r%5)-2)*256+((k%7)-3), B[k]=((k%9)-4)*128 -> each row equals the golden of per-beat floor-shifted row sums. Exactly 10 done_tile pulses.
- Negative floor: A row all -1, B all 1, k_tiles=1 -> row=-1, not 0.
- Backpressure: out_ready=0 for 20 cycles after group 1 completes while group 2 (k_tiles=4) streams -> group 2 is accepted, then in_ready stays 0 in DRAIN. out_y(group 1) is stable, and group 2 appears on the cycle after out_ready=1.
- Overflow, A=B=32767, k_tiles=200: with SATURATE_EN rows=2147483647 and sat_flag=1; without it rows=-939728896 and sat_flag=0.
- Reset after 3 of 8 beats -> outputs clear, no done_tile. The next group with k_tiles=1 is correct, with no residue from the aborted group.
